// File: rtl/uart_tx_arb.sv
// Two-requester byte arbiter feeding a single UART transmitter.
// Grants are held until end-of-line, burst limit or idle timeout, then released with one idle bubble.
//
// state | meaning
// IDLE  | no owner; pick next requester (round-robin on tie)
// GNT0  | requester 0 owns the transmitter
// GNT1  | requester 1 owns the transmitter
module uart_tx_arb #(
    parameter int          MAX_BURST    = 64,
    parameter logic [7:0]  EOL_CHAR     = 8'h0A,
    parameter int          IDLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic [IW-1:0] idle_cnt;
    logic          rr_ptr;

    logic          out_free;
    logic          acc0;
    logic          acc1;
    logic          acc;
    logic [7:0]    acc_data;
    logic [BW-1:0] burst_next;
    logic          hit_eol;
    logic          hit_burst;
    logic          hit_idle;
    logic          release_now;

    // The output register can take a new byte when empty or being drained this cycle.
    assign out_free   = ~tx_valid | tx_ready;
    assign req0_ready = (state == GNT0) & out_free;
    assign req1_ready = (state == GNT1) & out_free;

    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign acc        = acc0 | acc1;
    assign acc_data   = acc1 ? req1_data : req0_data;
    assign burst_next = burst_cnt + BW'(1);

    assign hit_eol     = acc && (acc_data == EOL_CHAR);
    assign hit_burst   = acc && (burst_next == BW'(MAX_BURST));
    assign hit_idle    = !acc && (idle_cnt == IW'(IDLE_TIMEOUT - 1));
    assign release_now = hit_eol | hit_burst | hit_idle;

    assign grant = {state == GNT1, state == GNT0};
    assign busy  = (state != IDLE) | tx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            rr_ptr    <= 1'b1;
        end else begin
            if (acc) begin
                tx_valid <= 1'b1;
                tx_data  <= acc_data;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    idle_cnt  <= '0;
                    // rr_ptr holds the last owner, so the other side wins a tie.
                    if (req0_valid && (!req1_valid || rr_ptr)) begin
                        state  <= GNT0;
                        rr_ptr <= 1'b0;
                    end else if (req1_valid) begin
                        state  <= GNT1;
                        rr_ptr <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (release_now) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end else if (acc) begin
                        burst_cnt <= burst_next;
                        idle_cnt  <= '0;
                    end else if (idle_cnt != IW'(IDLE_TIMEOUT)) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-requester source queues, a scoreboard of
// accepted bytes checked against tx output, and grant timing checks.
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic [1:0] grant;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int acc0_cnt = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp_q[$];
    bit en0 = 1'b0;
    bit en1 = 1'b0;

    logic [1:0] g_exp1 [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10};

    always #5 clk = ~clk;

    uart_tx_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Junk data while not valid must never leak into the output.
    task automatic drive();
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = req0_valid ? q0[0] : 8'($urandom);
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = req1_valid ? q1[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(negedge clk);
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("tx_spurious", tx_valid, 1'b0);
            else begin
                check("tx_data", tx_data, exp_q[0]);
                exp_q.delete(0);
            end
        end
        if (req0_valid && req0_ready) begin
            exp_q.push_back(req0_data);
            q0.delete(0);
            acc0_cnt++;
        end
        if (req1_valid && req1_ready) begin
            exp_q.push_back(req1_data);
            q1.delete(0);
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (((q0.size() > 0 && en0) || (q1.size() > 0 && en1) || busy || exp_q.size() > 0)
               && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        // Reset with both requesters already offering data.
        q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h0A);
        q1.push_back(8'h78); q1.push_back(8'h79); q1.push_back(8'h0A);
        en0 = 1'b1;
        en1 = 1'b1;
        tx_ready = 1'b1;
        rst = 1'b1;
        drive();
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);

        // Tie after reset goes to req0; "AB\n", one bubble, then req1.
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t1_grant_c%0d", k + 1), grant, g_exp1[k]);
        end
        drain(60, "t1");

        // 70-byte stream from req0 is cut at 64; req1 gets a turn, then req0 resumes.
        for (int i = 0; i < 70; i++) q0.push_back(8'(8'h20 + i));
        q1.push_back(8'h70); q1.push_back(8'h71); q1.push_back(8'h0A);
        acc0_cnt = 0;
        drive();
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 1 || k == 64) check($sformatf("t2_grant_c%0d", k), grant, 2'b01);
            if (k == 65) begin
                check("t2_grant_c65", grant, 2'b00);
                check("t2_burst_len", acc0_cnt, 64);
            end
            if (k == 66) check("t2_grant_c66", grant, 2'b10);
            if (k == 69) check("t2_grant_c69", grant, 2'b00);
            if (k == 70) check("t2_grant_c70", grant, 2'b01);
        end
        drain(100, "t2");

        // Back-pressure: 8'h41 held while tx_ready is low.
        en1 = 1'b0;
        tx_ready = 1'b0;
        q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43); q0.push_back(8'h0A);
        drive();
        tick();
        check("t3_grant", grant, 2'b01);
        tick();
        check("t3_first_valid", tx_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t3_hold_valid%0d", k), tx_valid, 1'b1);
            check($sformatf("t3_hold_data%0d", k), tx_data, 8'h41);
            check($sformatf("t3_hold_ready%0d", k), req0_ready, 1'b0);
        end
        tx_ready = 1'b1;
        #1;
        check("t3_ready_on_drain", req0_ready, 1'b1);
        tick();
        check("t3_next_data", tx_data, 8'h42);
        check("t3_next_valid", tx_valid, 1'b1);
        drain(60, "t3");

        // Idle timeout: req1 sends one byte and goes quiet while req0 waits.
        en0 = 1'b1;
        en1 = 1'b1;
        q1.push_back(8'h55);
        drive();
        tick();
        check("t4_grant", grant, 2'b10);
        tick();
        q0.push_back(8'h66); q0.push_back(8'h0A);
        drive();
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1)  check("t4_req0_waits", req0_ready, 1'b0);
            if (k == 15) check("t4_grant_c15", grant, 2'b10);
            if (k == 16) check("t4_grant_c16", grant, 2'b00);
            if (k == 17) check("t4_grant_c17", grant, 2'b01);
        end
        drain(60, "t4");

        // Reset in the middle of a GNT0 burst with a byte pending.
        en1 = 1'b0;
        tx_ready = 1'b0;
        q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h33); q0.push_back(8'h44);
        drive();
        tick();
        check("t5_grant", grant, 2'b01);
        tick();
        check("t5_pending", tx_valid, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        q0.delete();
        en0 = 1'b0;
        drive();
        tick();
        check("t5_rst_tx_valid", tx_valid, 1'b0);
        check("t5_rst_tx_data", tx_data, 8'h00);
        check("t5_rst_grant", grant, 2'b00);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b0;
        tx_ready = 1'b1;
        q0.push_back(8'hAA); q0.push_back(8'h0A);
        q1.push_back(8'hBB); q1.push_back(8'h0A);
        en0 = 1'b1;
        en1 = 1'b1;
        drive();
        tick();
        check("t5_tie_req0", grant, 2'b01);
        drain(60, "t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
